// File: rtl/adpll_pkg.sv
// Shared types, limits and the saturation helper for the ADPLL error path.
package adpll_pkg;

    typedef logic signed [7:0] error_t;

    typedef enum logic [1:0] {
        IDLE,
        REF_LEAD,
        DCO_LEAD
    } pd_state_t;

    localparam int ERR_MAX = 127;
    localparam int ERR_MIN = -128;

    // Clamp a 9-bit signed value into the signed 8-bit error range.
    function automatic error_t sat8(input logic signed [8:0] value);
        logic signed [8:0] hi;
        logic signed [8:0] lo;
        hi = 9'(ERR_MAX);
        lo = 9'(ERR_MIN);
        if (value > hi) begin
            return hi[7:0];
        end else if (value < lo) begin
            return lo[7:0];
        end else begin
            return value[7:0];
        end
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The single-cycle pulse appears three clock edges after the input rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [1:0] sync;
    logic       last;

    // Resynchronize the asynchronous input and register the rising-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            last  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            last  <= sync[1];
            pulse <= sync[1] & ~last;
        end
    end

endmodule

// File: rtl/error_combiner.sv
// Phase/frequency error combiner for the ADPLL loop filter.
// Measures the signed phase offset between reference and DCO feedback edges
// in gen_clk_i cycles, then publishes a saturated 8-bit error word.
// Optional macro FREQ_ERROR_EN adds a windowed frequency-error term.
module error_combiner
    import adpll_pkg::*;
#(
    parameter int FREQ_WIN  = 16,
    parameter int PHASE_MAX = 127
) (
    input  logic   gen_clk_i,
    input  logic   reset_i,
    input  logic   ref_clk_i,
    input  logic   dco_clk_i,
    output error_t error_o,
    output logic   error_valid_o
);

    localparam logic [6:0] CNT_MAX = 7'(PHASE_MAX);

    if (FREQ_WIN < 2 || FREQ_WIN > 64 || (FREQ_WIN & (FREQ_WIN - 1)) != 0) begin : g_bad_freq_win
        $error("error_combiner: FREQ_WIN must be a power of two in 2..64");
    end
    if (PHASE_MAX < 1 || PHASE_MAX > 127) begin : g_bad_phase_max
        $error("error_combiner: PHASE_MAX must be in 1..127");
    end

    logic ref_e;
    logic dco_e;

    edge_sync u_ref_sync (
        .clk   (gen_clk_i),
        .rst   (reset_i),
        .din   (ref_clk_i),
        .pulse (ref_e)
    );

    edge_sync u_dco_sync (
        .clk   (gen_clk_i),
        .rst   (reset_i),
        .din   (dco_clk_i),
        .pulse (dco_e)
    );

    pd_state_t         state;
    pd_state_t         state_next;
    logic [6:0]        cnt;
    logic [6:0]        cnt_next;
    logic [6:0]        cnt_inc;
    logic              publish;
    error_t            phase;
    error_t            freq_term;
    logic signed [8:0] sum;

    // The published count includes the current cycle, so it equals the edge offset.
    assign cnt_inc = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 7'd1;

    // Phase state and lead counter registers.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= 7'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Phase FSM: pair opening and closing edges and decide what to publish.
    always_comb begin
        state_next = state;
        cnt_next   = cnt_inc;
        publish    = 1'b0;
        phase      = '0;
        unique case (state)
            IDLE: begin
                cnt_next = 7'd0;
                if (ref_e && dco_e) begin
                    publish = 1'b1;
                end else if (ref_e) begin
                    state_next = REF_LEAD;
                end else if (dco_e) begin
                    state_next = DCO_LEAD;
                end
            end
            REF_LEAD: begin
                if (dco_e) begin
                    publish  = 1'b1;
                    phase    = $signed({1'b0, cnt_inc});
                    cnt_next = 7'd0;
                    if (!ref_e) begin
                        state_next = IDLE;
                    end
                end else if (ref_e) begin
                    publish  = 1'b1;
                    phase    = $signed({1'b0, CNT_MAX});
                    cnt_next = 7'd0;
                end
            end
            DCO_LEAD: begin
                if (ref_e) begin
                    publish  = 1'b1;
                    phase    = -$signed({1'b0, cnt_inc});
                    cnt_next = 7'd0;
                    if (!dco_e) begin
                        state_next = IDLE;
                    end
                end else if (dco_e) begin
                    publish  = 1'b1;
                    phase    = -$signed({1'b0, CNT_MAX});
                    cnt_next = 7'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 7'd0;
            end
        endcase
    end

`ifdef FREQ_ERROR_EN
    localparam logic [6:0] WIN_LAST = 7'(FREQ_WIN - 1);

    logic [6:0] ref_count;
    logic [7:0] dco_count;
    logic [7:0] dco_count_inc;
    error_t     freq_err;

    // A DCO edge in the closing cycle still belongs to the closing window.
    assign dco_count_inc = (dco_e && dco_count != 8'hFF) ? dco_count + 8'd1 : dco_count;

    // Count reference periods and DCO edges; capture the difference at window close.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_count <= 7'd0;
            dco_count <= 8'd0;
            freq_err  <= '0;
        end else if (ref_e && ref_count == WIN_LAST) begin
            ref_count <= 7'd0;
            dco_count <= 8'd0;
            freq_err  <= sat8($signed(9'(FREQ_WIN) - {1'b0, dco_count_inc}));
        end else begin
            if (ref_e) begin
                ref_count <= ref_count + 7'd1;
            end
            dco_count <= dco_count_inc;
        end
    end

    assign freq_term = freq_err;
`else
    assign freq_term = '0;
`endif

    assign sum = {phase[7], phase} + {freq_term[7], freq_term};

    // Output register: update the error word and strobe valid on each publish.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_o       <= '0;
            error_valid_o <= 1'b0;
        end else begin
            error_valid_o <= publish;
            if (publish) begin
                error_o <= sat8(sum);
            end
        end
    end

endmodule

// File: tb/tb_error_combiner.sv
// Directed self-checking bench for error_combiner.
// Frequency-term cases run only when FREQ_ERROR_EN is defined.
module tb_error_combiner;

    logic              gen_clk;
    logic              reset;
    logic              ref_clk;
    logic              dco_clk;
    logic signed [7:0] error;
    logic              error_valid;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] pubs[$];

    error_combiner #(
        .FREQ_WIN  (16),
        .PHASE_MAX (127)
    ) dut (
        .gen_clk_i     (gen_clk),
        .reset_i       (reset),
        .ref_clk_i     (ref_clk),
        .dco_clk_i     (dco_clk),
        .error_o       (error),
        .error_valid_o (error_valid)
    );

    initial gen_clk = 1'b0;
    always #5 gen_clk = ~gen_clk;

    // Record every published error word, sampled just after the active edge.
    always @(posedge gen_clk) begin
        #1;
        if (error_valid === 1'b1) begin
            pubs.push_back(error);
        end
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic levelAt(input int start, input int edges, input int period, input int t);
        if (edges <= 0 || t < start) return 1'b0;
        if ((t - start) / period >= edges) return 1'b0;
        return ((t - start) % period) < (period / 2);
    endfunction

    // Drive square waves on both inputs for a number of gen_clk cycles.
    task automatic applyStimulus(input int ref_start, input int ref_edges,
                                 input int dco_start, input int dco_edges,
                                 input int period, input int cycles);
        for (int t = 0; t < cycles; t++) begin
            @(negedge gen_clk);
            ref_clk = levelAt(ref_start, ref_edges, period, t);
            dco_clk = levelAt(dco_start, dco_edges, period, t);
        end
    endtask

    task automatic settle();
        @(negedge gen_clk);
        ref_clk = 1'b0;
        dco_clk = 1'b0;
        repeat (8) @(negedge gen_clk);
    endtask

    task automatic doReset();
        @(negedge gen_clk);
        reset   = 1'b1;
        ref_clk = 1'b0;
        dco_clk = 1'b0;
        repeat (2) @(negedge gen_clk);
        reset = 1'b0;
        repeat (2) @(negedge gen_clk);
        pubs.delete();
    endtask

    // Expect count_a copies of val_a followed by count_b copies of val_b.
    task automatic checkQueue(input string tag, input int count_a, input int val_a,
                              input int count_b, input int val_b);
        checkOutput({tag, " count"}, pubs.size(), count_a + count_b);
        for (int i = 0; i < pubs.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), pubs[i], (i < count_a) ? val_a : val_b);
        end
        pubs.delete();
    endtask

    initial begin
        reset   = 1'b1;
        ref_clk = 1'b0;
        dco_clk = 1'b0;
        repeat (3) @(negedge gen_clk);
        checkOutput("reset error", error, 0);
        checkOutput("reset valid", error_valid, 0);
        reset = 1'b0;
        repeat (3) @(negedge gen_clk);
        checkOutput("idle valid", error_valid, 0);
        pubs.delete();

        applyStimulus(10, 3, 15, 3, 40, 120);
        settle();
        checkQueue("dco lags", 3, 5, 0, 0);

        applyStimulus(10, 2, 10, 2, 40, 80);
        settle();
        checkQueue("simultaneous", 2, 0, 0, 0);
        checkOutput("simultaneous hold", error, 0);

        applyStimulus(10, 3, 3, 3, 40, 120);
        settle();
        checkQueue("dco leads", 3, -7, 0, 0);

        applyStimulus(10, 4, 0, 0, 40, 160);
        checkQueue("cycle slip", 3, 127, 0, 0);
        checkOutput("slip hold", error, 127);

        @(negedge gen_clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset error", error, 0);
        checkOutput("midreset valid", error_valid, 0);
        repeat (2) @(negedge gen_clk);
        reset = 1'b0;
        repeat (2) @(negedge gen_clk);
        checkQueue("during reset", 0, 0, 0, 0);
        applyStimulus(0, 0, 10, 1, 400, 30);
        checkOutput("post-reset open", pubs.size(), 0);
        applyStimulus(5, 1, 0, 0, 400, 30);
        settle();
        checkQueue("post-reset close", 1, -25, 0, 0);

        applyStimulus(10, 1, 160, 1, 400, 300);
        settle();
        checkQueue("count saturate", 1, 127, 0, 0);

`ifdef FREQ_ERROR_EN
        doReset();
        applyStimulus(10, 16, 13, 14, 40, 640);
        checkQueue("freq window", 14, 3, 1, 127);
        applyStimulus(0, 0, 90, 1, 400, 100);
        checkQueue("freq phase 120", 1, 122, 0, 0);
        applyStimulus(10, 1, 13, 1, 400, 40);
        settle();
        checkQueue("freq phase 3", 1, 5, 0, 0);

        doReset();
        applyStimulus(10, 16, 13, 10, 40, 640);
        checkQueue("sat window", 10, 3, 5, 127);
        applyStimulus(0, 0, 94, 1, 400, 100);
        checkQueue("sat clamp", 1, 127, 0, 0);
        applyStimulus(10, 1, 13, 1, 400, 40);
        settle();
        checkQueue("sat phase 3", 1, 9, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
